// File: rtl/sync_ram_bist_if.sv
// sync_ram_bist_if
//   Bundles the user access port and the BIST control/status of sync_ram_bist.
//   master : the agent issuing reads/writes and starting the self-test
//   slave  : the memory itself
//   Signals: cs, wr, addr, data_in, bist_start (master -> slave)
//            data_out, rd_valid, bist_busy, bist_done, bist_pass,
//            bist_fail_addr (slave -> master)
interface sync_ram_bist_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              cs;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              bist_start;
  logic              bist_busy;
  logic              bist_done;
  logic              bist_pass;
  logic [ADDR_W-1:0] bist_fail_addr;

  modport master (
    output cs, wr, addr, data_in, bist_start,
    input  data_out, rd_valid, bist_busy, bist_done, bist_pass, bist_fail_addr
  );

  modport slave (
    input  cs, wr, addr, data_in, bist_start,
    output data_out, rd_valid, bist_busy, bist_done, bist_pass, bist_fail_addr
  );
endinterface

// File: rtl/sync_ram_bist.sv
// sync_ram_bist
//   Single-port synchronous RAM (2**ADDR_W x DATA_W) with registered read and a
//   built-in self-test that writes (2*addr) mod 2**DATA_W to every word, reads
//   it all back and reports pass/fail with the first failing address.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset (array contents are kept)
//     bus  : sync_ram_bist_if.slave -- user access (cs/wr/addr/data_in,
//            data_out/rd_valid) and BIST control/status
//   FAULT_ADDR >= 0 forces bit 0 of the word read from that address to 1,
//   which lets a simulation exercise the failure path of the self-test.
module sync_ram_bist #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int FAULT_ADDR = -1
) (
  input  logic           clk,
  input  logic           rst,
  sync_ram_bist_if.slave bus
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] ZERO_D   = {DATA_W{1'b0}};
  localparam int                FAULT_U  = (FAULT_ADDR < 0) ? 0 : FAULT_ADDR;
  localparam logic              FAULT_EN = (FAULT_ADDR >= 0);
  localparam logic [ADDR_W-1:0] FAULT_A  = ADDR_W'(FAULT_U);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_LAST  = 2'd3
  } state_t;

  // Test pattern: twice the address, truncated to the data width.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return DATA_W'({a, 1'b0});
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];

  state_t            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] cmp_addr_r;
  logic [DATA_W-1:0] bist_rd_r;
  logic              cmp_vld_r;
  logic              fail_flag_r;
  logic [ADDR_W-1:0] fail_addr_r;
  logic [DATA_W-1:0] data_out_r;
  logic              rd_valid_r;
  logic              busy_r;
  logic              done_r;
  logic              pass_r;

  logic              start_s;
  logic              user_rd_s;
  logic              user_wr_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] mem_rdata_s;
  logic              fault_hit_s;
  logic              mismatch_s;

  // Decode user requests; only honoured in IDLE, and a BIST start wins.
  always_comb begin
    start_s   = 1'b0;
    user_rd_s = 1'b0;
    user_wr_s = 1'b0;
    if (state_r == ST_IDLE) begin
      start_s   = bus.bist_start;
      user_wr_s = bus.cs & bus.wr & ~bus.bist_start;
      user_rd_s = bus.cs & ~bus.wr & ~bus.bist_start;
    end else begin
      start_s   = 1'b0;
      user_rd_s = 1'b0;
      user_wr_s = 1'b0;
    end
  end

  // Single array port: user owns it in IDLE, the BIST pointer otherwise.
  // Writes are blocked while rst is high so an aborted test stops at once.
  always_comb begin
    mem_addr_s  = ptr_r;
    mem_wdata_s = pattern(ptr_r);
    mem_we_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mem_addr_s  = bus.addr;
        mem_wdata_s = bus.data_in;
        mem_we_s    = user_wr_s & ~rst;
      end
      ST_WRITE: begin
        mem_addr_s  = ptr_r;
        mem_wdata_s = pattern(ptr_r);
        mem_we_s    = ~rst;
      end
      default: begin
        mem_addr_s  = ptr_r;
        mem_wdata_s = pattern(ptr_r);
        mem_we_s    = 1'b0;
      end
    endcase
  end

  assign fault_hit_s = FAULT_EN && (mem_addr_s == FAULT_A);
  assign mem_rdata_s = mem_r[mem_addr_s] | {{(DATA_W-1){1'b0}}, fault_hit_s};

  // The word captured on the previous READ edge is checked against its pattern.
  assign mismatch_s  = cmp_vld_r && (bist_rd_r != pattern(cmp_addr_r));

  // Array write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

  // Control FSM, user read register and all registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= ZERO_A;
      cmp_addr_r  <= ZERO_A;
      bist_rd_r   <= ZERO_D;
      cmp_vld_r   <= 1'b0;
      fail_flag_r <= 1'b0;
      fail_addr_r <= ZERO_A;
      data_out_r  <= ZERO_D;
      rd_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r     <= ST_WRITE;
            ptr_r       <= ZERO_A;
            cmp_vld_r   <= 1'b0;
            fail_flag_r <= 1'b0;
            fail_addr_r <= ZERO_A;
            pass_r      <= 1'b0;
            busy_r      <= 1'b1;
          end else if (user_rd_s) begin
            data_out_r <= mem_rdata_s;
            rd_valid_r <= 1'b1;
          end
        end
        ST_WRITE: begin
          ptr_r <= ptr_r + ONE_A;
          if (ptr_r == LAST_PTR) begin
            state_r <= ST_READ;
          end
        end
        ST_READ: begin
          bist_rd_r  <= mem_rdata_s;
          cmp_addr_r <= ptr_r;
          cmp_vld_r  <= 1'b1;
          ptr_r      <= ptr_r + ONE_A;
          if (mismatch_s && !fail_flag_r) begin
            fail_flag_r <= 1'b1;
            fail_addr_r <= cmp_addr_r;
          end
          if (ptr_r == LAST_PTR) begin
            state_r <= ST_LAST;
          end
        end
        ST_LAST: begin
          if (mismatch_s && !fail_flag_r) begin
            fail_flag_r <= 1'b1;
            fail_addr_r <= cmp_addr_r;
          end
          cmp_vld_r <= 1'b0;
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b1;
          pass_r    <= ~(fail_flag_r | mismatch_s);
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out       = data_out_r;
  assign bus.rd_valid       = rd_valid_r;
  assign bus.bist_busy      = busy_r;
  assign bus.bist_done      = done_r;
  assign bus.bist_pass      = pass_r;
  assign bus.bist_fail_addr = fail_addr_r;

endmodule
